// File: rtl/i2c_expander_target.sv
`default_nettype none
// ============================================================================
// Module   : i2c_expander_target
// Brief    : I2C target modelling a 16-bit GPIO expander with an 8-register
//            file (input 0/1, output 2/3, polarity 4/5, config 6/7).
//            SCL/SDA are synchronised and glitch-filtered on clk48.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_expander_target #(
    parameter logic [6:0] ADDRESS    = 7'h25,
    parameter int         FILTER_LEN = 3
) (
    input  logic        clk48,
    input  logic        reset,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] in_port,
    output logic [15:0] out_port,
    output logic [15:0] polarity,
    // "config" is a reserved word in SystemVerilog, hence the suffix
    output logic [15:0] config_port,
    output logic        write_strobe,
    output logic [2:0]  write_index,
    output logic        busy
);

    localparam logic [3:0] c_ST_IDLE      = 4'd0;
    localparam logic [3:0] c_ST_ADDR      = 4'd1;
    localparam logic [3:0] c_ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] c_ST_PTR       = 4'd3;
    localparam logic [3:0] c_ST_PTR_ACK   = 4'd4;
    localparam logic [3:0] c_ST_WDATA     = 4'd5;
    localparam logic [3:0] c_ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] c_ST_RDATA     = 4'd7;
    localparam logic [3:0] c_ST_RDATA_ACK = 4'd8;
    localparam logic [3:0] c_ST_IGNORE    = 4'd9;

    logic                  r_scl_meta, r_scl_sync, r_sda_meta, r_sda_sync;
    logic [FILTER_LEN-1:0] r_scl_hist, r_sda_hist;
    logic                  r_scl_filt, r_sda_filt, r_scl_prev, r_sda_prev;

    logic [3:0] r_state, w_state_nxt;
    logic [2:0] r_bitcnt, r_ptr, r_write_index;
    logic [6:0] r_shift;      // first seven bits of the byte in flight
    logic [6:0] r_rd;         // remaining read bits; bit 7 goes straight out at load
    logic       r_rw, r_ack_rose, r_sda_oe, r_busy, r_write_strobe;
    logic       w_sda_oe_d, w_busy_d;
    logic [7:0] r_regs [2:7];
    logic [7:0] w_byte, w_rd_val;
    logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_addr_match, w_in_ack;

    // Two-flop synchroniser, then accept a level only after FILTER_LEN equal samples
    always_ff @(posedge clk48) begin
        if (reset) begin
            r_scl_meta <= 1'b1;  r_scl_sync <= 1'b1;
            r_sda_meta <= 1'b1;  r_sda_sync <= 1'b1;
            r_scl_hist <= '1;    r_sda_hist <= '1;
            r_scl_filt <= 1'b1;  r_sda_filt <= 1'b1;
            r_scl_prev <= 1'b1;  r_sda_prev <= 1'b1;
        end else begin
            r_scl_meta <= scl_in;  r_scl_sync <= r_scl_meta;
            r_sda_meta <= sda_in;  r_sda_sync <= r_sda_meta;
            r_scl_hist <= {r_scl_hist[FILTER_LEN-2:0], r_scl_sync};
            r_sda_hist <= {r_sda_hist[FILTER_LEN-2:0], r_sda_sync};
            if (&r_scl_hist)       r_scl_filt <= 1'b1;
            else if (~|r_scl_hist) r_scl_filt <= 1'b0;
            if (&r_sda_hist)       r_sda_filt <= 1'b1;
            else if (~|r_sda_hist) r_sda_filt <= 1'b0;
            r_scl_prev <= r_scl_filt;
            r_sda_prev <= r_sda_filt;
        end
    end

    assign w_scl_rise   = r_scl_filt & ~r_scl_prev;
    assign w_scl_fall   = ~r_scl_filt & r_scl_prev;
    assign w_start      = r_scl_filt & r_scl_prev & r_sda_prev & ~r_sda_filt;
    assign w_stop       = r_scl_filt & r_scl_prev & ~r_sda_prev & r_sda_filt;
    assign w_byte       = {r_shift, r_sda_filt};
    assign w_addr_match = (w_byte[7:1] == ADDRESS);
    assign w_in_ack     = (r_state == c_ST_ADDR_ACK) || (r_state == c_ST_PTR_ACK) ||
                          (r_state == c_ST_WDATA_ACK);

    // Read-value mux; input registers are pin levels corrected by polarity
    always_comb begin
        case (r_ptr)
            3'd0:    w_rd_val = in_port[7:0]  ^ r_regs[4];
            3'd1:    w_rd_val = in_port[15:8] ^ r_regs[5];
            default: w_rd_val = r_regs[r_ptr];
        endcase
    end

    // State register
    always_ff @(posedge clk48) begin
        if (reset) r_state <= c_ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state logic; bus conditions override bit processing
    always_comb begin
        w_state_nxt = r_state;
        if (w_start) begin
            w_state_nxt = c_ST_ADDR;
        end else if (w_stop) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_ADDR:
                    if (w_scl_rise && r_bitcnt == 3'd7)
                        w_state_nxt = w_addr_match ? c_ST_ADDR_ACK : c_ST_IGNORE;
                c_ST_ADDR_ACK:
                    if (w_scl_fall && r_ack_rose) w_state_nxt = r_rw ? c_ST_RDATA : c_ST_PTR;
                c_ST_PTR:
                    if (w_scl_rise && r_bitcnt == 3'd7) w_state_nxt = c_ST_PTR_ACK;
                c_ST_PTR_ACK, c_ST_WDATA_ACK:
                    if (w_scl_fall && r_ack_rose) w_state_nxt = c_ST_WDATA;
                c_ST_WDATA:
                    if (w_scl_rise && r_bitcnt == 3'd7) w_state_nxt = c_ST_WDATA_ACK;
                // bit counter has wrapped to 0 after the 8th rise
                c_ST_RDATA:
                    if (w_scl_fall && r_bitcnt == 3'd0) w_state_nxt = c_ST_RDATA_ACK;
                c_ST_RDATA_ACK: begin
                    if (w_scl_rise && r_sda_filt)          w_state_nxt = c_ST_IGNORE;
                    else if (w_scl_fall && r_ack_rose)     w_state_nxt = c_ST_RDATA;
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Output logic: next SDA drive (only ever changed on SCL fall) and busy
    always_comb begin
        w_sda_oe_d = r_sda_oe;
        w_busy_d   = r_busy;
        if (w_start) begin
            w_sda_oe_d = 1'b0;
        end else if (w_stop) begin
            w_sda_oe_d = 1'b0;
            w_busy_d   = 1'b0;
        end else begin
            case (r_state)
                c_ST_ADDR:
                    if (w_scl_rise && r_bitcnt == 3'd7) w_busy_d = w_addr_match;
                c_ST_ADDR_ACK, c_ST_PTR_ACK, c_ST_WDATA_ACK:
                    if (w_scl_fall) begin
                        if (!r_ack_rose)                             w_sda_oe_d = 1'b1;
                        else if (r_state == c_ST_ADDR_ACK && r_rw)   w_sda_oe_d = ~w_rd_val[7];
                        else                                         w_sda_oe_d = 1'b0;
                    end
                c_ST_RDATA:
                    if (w_scl_fall) w_sda_oe_d = (r_bitcnt == 3'd0) ? 1'b0 : ~r_rd[6];
                c_ST_RDATA_ACK: begin
                    if (w_scl_rise && r_sda_filt)      w_busy_d   = 1'b0;
                    if (w_scl_fall && r_ack_rose)      w_sda_oe_d = ~w_rd_val[7];
                end
                c_ST_IGNORE: begin
                    w_sda_oe_d = 1'b0;
                    w_busy_d   = 1'b0;
                end
                default: w_sda_oe_d = 1'b0;
            endcase
        end
    end

    // Datapath: shifting, pointer, register file and write strobe
    always_ff @(posedge clk48) begin
        if (reset) begin
            r_sda_oe       <= 1'b0;
            r_busy         <= 1'b0;
            r_write_strobe <= 1'b0;
            r_write_index  <= 3'd0;
            r_ptr          <= 3'd0;
            r_bitcnt       <= 3'd0;
            r_shift        <= 7'd0;
            r_rd           <= 7'd0;
            r_rw           <= 1'b0;
            r_ack_rose     <= 1'b0;
            r_regs[2]      <= 8'hFF;
            r_regs[3]      <= 8'hFF;
            r_regs[4]      <= 8'h00;
            r_regs[5]      <= 8'h00;
            r_regs[6]      <= 8'hFF;
            r_regs[7]      <= 8'hFF;
        end else begin
            r_sda_oe       <= w_sda_oe_d;
            r_busy         <= w_busy_d;
            r_write_strobe <= 1'b0;
            if (w_start || w_stop) begin
                r_bitcnt   <= 3'd0;
                r_ack_rose <= 1'b0;
            end else begin
                case (r_state)
                    c_ST_ADDR, c_ST_PTR, c_ST_WDATA:
                        if (w_scl_rise) begin
                            r_shift  <= w_byte[6:0];
                            r_bitcnt <= r_bitcnt + 3'd1;
                            if (r_bitcnt == 3'd7) begin
                                if (r_state == c_ST_ADDR) r_rw  <= w_byte[0];
                                if (r_state == c_ST_PTR)  r_ptr <= w_byte[2:0];
                                if (r_state == c_ST_WDATA) begin
                                    // input registers accept the byte but keep pin values
                                    if (r_ptr >= 3'd2) r_regs[r_ptr] <= w_byte;
                                    r_write_strobe <= 1'b1;
                                    r_write_index  <= r_ptr;
                                    r_ptr          <= {r_ptr[2:1], ~r_ptr[0]};
                                end
                            end
                        end
                    c_ST_RDATA:
                        if (w_scl_rise)                          r_bitcnt <= r_bitcnt + 3'd1;
                        else if (w_scl_fall && r_bitcnt != 3'd0) r_rd     <= {r_rd[5:0], 1'b0};
                    c_ST_RDATA_ACK:
                        if (w_scl_rise) begin
                            if (!r_sda_filt) begin
                                r_ptr      <= {r_ptr[2:1], ~r_ptr[0]};
                                r_ack_rose <= 1'b1;
                            end
                        end else if (w_scl_fall && r_ack_rose) begin
                            r_rd       <= w_rd_val[6:0];
                            r_ack_rose <= 1'b0;
                        end
                    default:
                        if (w_in_ack) begin
                            if (w_scl_rise) begin
                                r_ack_rose <= 1'b1;
                            end else if (w_scl_fall && r_ack_rose) begin
                                r_ack_rose <= 1'b0;
                                if (r_state == c_ST_ADDR_ACK && r_rw) r_rd <= w_rd_val[6:0];
                            end
                        end
                endcase
            end
        end
    end

    assign sda_oe       = r_sda_oe;
    assign busy         = r_busy;
    assign write_strobe = r_write_strobe;
    assign write_index  = r_write_index;
    assign out_port     = {r_regs[3], r_regs[2]};
    assign polarity     = {r_regs[5], r_regs[4]};
    assign config_port  = {r_regs[7], r_regs[6]};

endmodule
`default_nettype wire

// File: tb/tb_i2c_expander_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_expander_target
// Brief    : Directed bench for i2c_expander_target: writes, repeated-start
//            read, address mismatch, aborts, reset mid-read, SCL glitches.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_expander_target;

    localparam int c_T = 10;   // quarter SCL period in clk48 cycles

    logic        clk48 = 1'b0;
    logic        reset = 1'b1;
    logic        scl = 1'b1;
    logic        sda_drv = 1'b1;
    logic [15:0] in_port = 16'hA55A;
    logic        sda_oe, write_strobe, busy;
    logic [15:0] out_port, polarity, config_port;
    logic [2:0]  write_index;
    logic        w_sda_bus;

    assign w_sda_bus = sda_drv & ~sda_oe;

    always #10 clk48 = ~clk48;

    i2c_expander_target #(.ADDRESS(7'h25), .FILTER_LEN(3)) dut (
        .clk48(clk48), .reset(reset), .scl_in(scl), .sda_in(w_sda_bus),
        .sda_oe(sda_oe), .in_port(in_port), .out_port(out_port),
        .polarity(polarity), .config_port(config_port),
        .write_strobe(write_strobe), .write_index(write_index), .busy(busy)
    );

    int n_cmp = 0, n_fail = 0;
    int strobe_cnt = 0, oe_cnt = 0, busy_cnt = 0;
    logic [2:0] idx_log [0:15];

    // Event monitor, sampled on the inactive edge
    always @(negedge clk48) begin
        if (write_strobe) begin
            idx_log[strobe_cnt[3:0]] <= write_index;
            strobe_cnt <= strobe_cnt + 1;
        end
        if (sda_oe) oe_cnt   <= oe_cnt + 1;
        if (busy)   busy_cnt <= busy_cnt + 1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk48);
        #1;
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; cyc(c_T);
        scl = 1'b1;     cyc(c_T);
        sda_drv = 1'b0; cyc(c_T);
        scl = 1'b0;
    endtask

    task automatic i2c_stop();
        cyc(c_T); sda_drv = 1'b0;
        cyc(c_T); scl = 1'b1;
        cyc(c_T); sda_drv = 1'b1;
        cyc(c_T);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        cyc(c_T); sda_drv = b;
        cyc(c_T); scl = 1'b1;
        cyc(c_T); s = w_sda_bus;
        cyc(c_T); scl = 1'b0;
    endtask

    // Same bit but with a one-cycle SCL pulse in the low and the high phase
    task automatic clock_bit_glitch(input logic b, output logic s);
        cyc(c_T); sda_drv = b;
        cyc(4); scl = 1'b1; cyc(1); scl = 1'b0;
        cyc(c_T - 5); scl = 1'b1;
        cyc(4); scl = 1'b0; cyc(1); scl = 1'b1;
        cyc(c_T - 5); s = w_sda_bus;
        cyc(c_T); scl = 1'b0;
    endtask

    // ack output: bus level seen at the 9th clock (0 = ACK)
    task automatic write_byte(input logic [7:0] d, input logic glitch, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            if (glitch) clock_bit_glitch(d[i], s);
            else        clock_bit(d[i], s);
        end
        clock_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(1'b1, d[i]);
        clock_bit(nack, s);
        sda_drv = 1'b1;
    endtask

    logic       ack;
    logic [7:0] rbyte;
    int         s0, o0, b0;

    initial begin
        // ---- reset state ----
        cyc(5);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_out_port", out_port, 16'hFFFF);
        check("rst_polarity", polarity, 16'h0000);
        check("rst_config", config_port, 16'hFFFF);
        check("rst_strobe", write_strobe, 1'b0);
        check("rst_index", write_index, 3'd0);
        reset = 1'b0;
        cyc(20);

        // ---- write config pair: ptr 6, data 00 -> reg6, 02 -> reg7 ----
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'h4A, 1'b0, ack); check("wr_ack_addr", ack, 1'b0);
        check("wr_busy_mid", busy, 1'b1);
        write_byte(8'h06, 1'b0, ack); check("wr_ack_ptr", ack, 1'b0);
        write_byte(8'h00, 1'b0, ack); check("wr_ack_d0", ack, 1'b0);
        write_byte(8'h02, 1'b0, ack); check("wr_ack_d1", ack, 1'b0);
        i2c_stop();
        cyc(10);
        check("wr_config", config_port, 16'h0200);
        check("wr_out_port", out_port, 16'hFFFF);
        check("wr_strobes", 16'(strobe_cnt - s0), 16'd2);
        check("wr_index0", idx_log[s0[3:0]], 3'd6);
        check("wr_index1", idx_log[s0[3:0] + 4'd1], 3'd7);
        check("wr_busy_after", busy, 1'b0);

        // ---- polarity FF/FF, then read inputs after a repeated start ----
        i2c_start();
        write_byte(8'h4A, 1'b0, ack);
        write_byte(8'h04, 1'b0, ack);
        write_byte(8'hFF, 1'b0, ack);
        write_byte(8'hFF, 1'b0, ack); check("pol_ack", ack, 1'b0);
        i2c_stop();
        cyc(10);
        check("pol_value", polarity, 16'hFFFF);
        i2c_start();
        write_byte(8'h4A, 1'b0, ack);
        write_byte(8'h00, 1'b0, ack); check("rd_ack_ptr", ack, 1'b0);
        i2c_start();
        write_byte(8'h4B, 1'b0, ack); check("rd_ack_addr", ack, 1'b0);
        // reg0 = 5A ^ FF, reg1 = A5 ^ FF
        read_byte(1'b0, rbyte); check("rd_byte0", rbyte, 8'hA5);
        read_byte(1'b1, rbyte); check("rd_byte1", rbyte, 8'h5A);
        cyc(5);
        check("rd_busy_after_nack", busy, 1'b0);
        check("rd_released", sda_oe, 1'b0);
        i2c_stop();

        // ---- address mismatch ----
        s0 = strobe_cnt; o0 = oe_cnt; b0 = busy_cnt;
        i2c_start();
        write_byte(8'h4C, 1'b0, ack); check("mm_nack_addr", ack, 1'b1);
        write_byte(8'h06, 1'b0, ack);
        write_byte(8'h55, 1'b0, ack); check("mm_nack_data", ack, 1'b1);
        i2c_stop();
        cyc(10);
        check("mm_oe_never", 16'(oe_cnt - o0), 16'd0);
        check("mm_busy_never", 16'(busy_cnt - b0), 16'd0);
        check("mm_config", config_port, 16'h0200);
        check("mm_strobes", 16'(strobe_cnt - s0), 16'd0);

        // ---- write to input register 0 is ACKed and dropped ----
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'h4A, 1'b0, ack);
        write_byte(8'h00, 1'b0, ack);
        write_byte(8'h12, 1'b0, ack); check("in_ack", ack, 1'b0);
        i2c_stop();
        cyc(10);
        check("in_strobes", 16'(strobe_cnt - s0), 16'd1);
        check("in_index", idx_log[s0[3:0]], 3'd0);
        check("in_out_port", out_port, 16'hFFFF);
        check("in_polarity", polarity, 16'hFFFF);
        check("in_config", config_port, 16'h0200);

        // ---- STOP after 4 data bits: no write ----
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'h4A, 1'b0, ack);
        write_byte(8'h02, 1'b0, ack);
        for (int i = 0; i < 4; i++) clock_bit(1'b0, ack);
        i2c_stop();
        cyc(10);
        check("ab_out_port", out_port, 16'hFFFF);
        check("ab_strobes", 16'(strobe_cnt - s0), 16'd0);
        check("ab_busy", busy, 1'b0);

        // ---- SCL glitches during a data byte: 3C -> reg3 ----
        s0 = strobe_cnt;
        i2c_start();
        write_byte(8'h4A, 1'b0, ack);
        write_byte(8'h03, 1'b0, ack);
        write_byte(8'h3C, 1'b1, ack); check("gl_ack", ack, 1'b0);
        i2c_stop();
        cyc(10);
        check("gl_out_port", out_port, 16'h3CFF);
        check("gl_strobes", 16'(strobe_cnt - s0), 16'd1);
        check("gl_index", idx_log[s0[3:0]], 3'd3);

        // ---- reset mid-RDATA: reg6 = 00, so the first bit drives SDA low ----
        i2c_start();
        write_byte(8'h4A, 1'b0, ack);
        write_byte(8'h06, 1'b0, ack);
        i2c_start();
        write_byte(8'h4B, 1'b0, ack); check("rr_ack_addr", ack, 1'b0);
        cyc(15);
        check("rr_driving", sda_oe, 1'b1);
        reset = 1'b1;
        cyc(1);
        check("rr_release", sda_oe, 1'b0);
        cyc(3);
        check("rr_busy", busy, 1'b0);
        check("rr_config", config_port, 16'hFFFF);
        check("rr_out_port", out_port, 16'hFFFF);
        check("rr_polarity", polarity, 16'h0000);
        check("rr_index", write_index, 3'd0);
        scl = 1'b1; sda_drv = 1'b1;
        cyc(10);
        reset = 1'b0;
        cyc(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/i2c_expander_target.md
Name: i2c_expander_target

Overview:
- I2C target (responder) modelling the 16-bit GPIO expander that the board's I2C master sequencer drives at address 0x25.
- Oversamples SCL/SDA on clk48, decodes START/STOP, matches the 7-bit address, and ACKs each byte.
- Serves an 8-register file: input 0/1, output 2/3, polarity 4/5, config 6/7.
- Used as the bus-functional responder in system simulation. It can also be instantiated on-FPGA as a soft expander behind a spare I2C header.

Parameters:
- ADDRESS, 7'h25, 7-bit target address (compared against address byte bits [7:1]).
- FILTER_LEN, 3, consecutive equal clk48 samples required to accept a new SCL/SDA level (glitch filter).

Ports:
- clk48  input  1  system clock, 48 MHz.
- reset  input  1  synchronous, active-high reset.
- scl_in  input  1  raw SCL pin level (asynchronous).
- sda_in  input  1  raw SDA pin level (asynchronous).
- sda_oe  output  1  1 = pull SDA low (open-drain); 0 = release.
- in_port  input  16  external pin levels; [7:0] = port 0, [15:8] = port 1.
- out_port  output  16  {reg3, reg2}.
- polarity  output  16  {reg5, reg4}.
- config  output  16  {reg7, reg6}; 1 = pin is an input.
- write_strobe  output  1  one-cycle pulse after a data byte is written to a register.
- write_index  output  3  register index of the last write; valid with write_strobe.
- busy  output  1  high from an address-matched START until STOP or until the target releases the bus.

Behaviour:
- Input conditioning:
  - 2-FF synchronizer on each of SCL and SDA, followed by the FILTER_LEN glitch filter.
  - All edges below refer to the filtered signals.
- Bus conditions:
  - START = SDA falls while SCL high.
  - STOP = SDA rises while SCL high.
  - Data bits are sampled on SCL rise. sda_oe changes only on SCL fall, one clk48 after the fall is detected.
- Reset:
  - Registers: sda_oe=0, busy=0, write_strobe=0, write_index=0, ptr=0.
  - Register defaults: reg2=reg3=8'hFF, reg4=reg5=8'h00, reg6=reg7=8'hFF.
  - State = IDLE.
  - A reset asserted mid-transfer releases SDA in the next cycle and discards the transaction.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
  - START from any state -> ADDR, bit counter cleared. ptr is kept, so a repeated start followed by a read uses the pointer set by the preceding write.
  - STOP from any state -> IDLE, sda_oe=0, busy=0. A partially received byte is discarded with no register write.
  - ADDR: shift in 8 bits MSB-first.
    - Bits [7:1] == ADDRESS -> ADDR_ACK and busy=1.
    - Mismatch -> IGNORE. SDA is never driven in IGNORE.
  - ADDR_ACK: drive 0 for the 9th clock.
    - R/W=0 -> PTR.
    - R/W=1 -> load the read shift register from reg[ptr] at the ACK-clock SCL fall, then RDATA.
  - PTR: 8 bits; ptr <= byte[2:0]. Upper bits are ignored and the byte is still ACKed. Then PTR_ACK -> WDATA.
  - WDATA: 8 bits, then ACK.
    - At the byte's 8th SCL rise, write reg[ptr] unless ptr is 0 or 1. Writes to 0/1 are ACKed and dropped.
    - write_strobe pulses for 1 cycle with write_index = ptr, including for dropped writes to 0/1.
    - ptr <= {ptr[2:1], ~ptr[0]} (toggle within the pair). Repeat WDATA.
  - RDATA: drive the shift register MSB-first, each bit changing on SCL fall. Release at the 8th fall -> RDATA_ACK.
  - RDATA_ACK: sample the controller's bit at SCL rise.
    - ACK (0): toggle ptr[0], load reg[new ptr] at the following SCL fall, then RDATA.
    - NACK (1): -> IGNORE, SDA released until START/STOP.
- Read values:
  - reg0 = in_port[7:0] ^ reg4; reg1 = in_port[15:8] ^ reg5.
  - Input values are snapshotted at shift-register load, never mid-byte.
- Simultaneous events: START/STOP take priority over bit processing in the same cycle.

Test Plan:
- Write: START, 0x4A, 0x06, 0x00, 0x02, STOP → every byte ACKed.
  - config[7:0]=0x00 and config[15:8]=0x02 (the pair toggle 6→7 places the second data byte in reg7).
  - Two write_strobe pulses with write_index 6 then 7.
  - out_port stays 0xFFFF.
- Read after repeated start: in_port=16'hA55A, reg4=0xFF; START, 0x4A, 0x00, rSTART, 0x4B, read 2 bytes with ACK then NACK, STOP → 0xA5 then 0x5A.
- Address mismatch: START, 0x4C, ... → sda_oe never asserted, no register changes, busy stays 0.
- Write to input register: START, 0x4A, 0x00, 0x12, STOP → byte ACKed, write_strobe pulses with write_index 0, no register change.
- Aborts:
  - STOP after 4 data bits → no write, busy=0.
  - reset mid-RDATA → sda_oe=0 next cycle, registers at defaults.
- 1-cycle glitches on SCL (FILTER_LEN=3) during a byte → the received byte is unaffected.
